count_seq_ctrl: RTL and testbench



---
 rtl/count_seq_ctrl_if.sv | 29 ++
 rtl/count_seq_ctrl.sv | 109 ++++++++++
 tb/tb_count_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/count_seq_ctrl_if.sv
// Control/config/status bundle between a sequencing master and count_seq_ctrl.
// Latency: none (wires only); the slave registers everything it drives.
// Backpressure: cfg_ready qualifies cfg_valid; start/stop/pause are unqualified levels.
interface count_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_limit;
    logic             cfg_ready;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    // Control side: issues commands and limit writes, observes status.
    modport master (
        output start, stop, pause, cfg_valid, cfg_limit,
        input  cfg_ready, count, busy, done, state
    );

    // Controller side: owns the count register and publishes status.
    modport slave (
        input  start, stop, pause, cfg_valid, cfg_limit,
        output cfg_ready, count, busy, done, state
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Sequences a WIDTH-bit up-counter from 0 to a programmed limit with start/stop/pause and a done pulse.
// Latency: start sampled at edge T gives count=k after T+k; done pulses after T+L+1; all outputs registered/state-decoded.
// Backpressure: cfg writes accepted only in IDLE/DONE (cfg_ready); define COUNT_SEQ_AUTO_RELOAD_EN to restart at the limit instead of entering DONE.
module count_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    count_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic             done_q;

    logic             cfg_ready_d;
    logic             cfg_wr_d;
    logic             at_limit_d;
    logic [WIDTH-1:0] count_inc_d;

    // Decode handshake and terminal conditions from registered state only.
    always_comb begin
        cfg_ready_d = (state_q == IDLE) || (state_q == DONE);
        cfg_wr_d    = bus.cfg_valid && cfg_ready_d;
        at_limit_d  = (count_q == limit_q);
        count_inc_d = count_q + 1'b1;
    end

    // Sequencer FSM: stop > pause > terminal > increment while running; done is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // A limit write and a start on the same edge both take effect;
            // the terminal check is only made from the next edge on, so the
            // new run sees the new limit.
            if (cfg_wr_d) begin
                limit_q <= bus.cfg_limit;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else if (bus.start) begin
                        state_q <= RUN;
                        count_q <= '0;
                    end
                end

                RUN: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else if (bus.pause) begin
                        state_q <= PAUSE;
                    end else if (at_limit_d) begin
                        done_q <= 1'b1;
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
                        // Continuous mode: wrap to zero and keep running.
                        count_q <= '0;
`else
                        // Single-shot: park at the limit until restarted.
                        state_q <= DONE;
`endif
                    end else begin
                        // Cannot overflow: the terminal check above fires first.
                        count_q <= count_inc_d;
                    end
                end

                PAUSE: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else if (!bus.pause) begin
                        state_q <= RUN;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign bus.state     = state_q;
    assign bus.count     = count_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q == RUN) || (state_q == PAUSE);
    assign bus.cfg_ready = cfg_ready_d;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with an abstract reference model checked every cycle.
// Latency: model advances on each posedge from the inputs seen there; outputs compared on the negedge.
// Backpressure: n/a; stimulus drives fixed cycle counts so the run always terminates.
module tb_count_seq_ctrl;

    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    count_seq_ctrl_if #(.WIDTH(W)) bus ();

    count_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model, in plain integers. State numbering is the published status encoding.
    int m_state = 0;
    int m_count = 0;
    int m_limit = MAXV;
    int m_done  = 0;

    function automatic void check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step();
        int  ns, nc, nl, nd;
        bit  can_cfg;
        ns = m_state; nc = m_count; nl = m_limit; nd = 0;
        if (rst) begin
            ns = 0; nc = 0; nl = MAXV; nd = 0;
        end else begin
            can_cfg = (m_state == 0) || (m_state == 3);
            if (bus.cfg_valid && can_cfg) nl = int'(bus.cfg_limit);
            if (can_cfg) begin
                if (bus.stop)       begin ns = 0; nc = 0; end
                else if (bus.start) begin ns = 1; nc = 0; end
            end else if (bus.stop) begin
                ns = 0; nc = 0;
            end else if (m_state == 2) begin
                if (!bus.pause) ns = 1;
            end else if (bus.pause) begin
                ns = 2;
            end else if (m_count == m_limit) begin
                nd = 1;
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
                nc = 0;
`else
                ns = 3;
`endif
            end else begin
                nc = m_count + 1;
            end
        end
        m_state = ns; m_count = nc; m_limit = nl; m_done = nd;
    endfunction

    function automatic void compare_all();
        check("state",     int'(bus.state),     m_state);
        check("count",     int'(bus.count),     m_count);
        check("done",      int'(bus.done),      m_done);
        check("busy",      int'(bus.busy),      int'(m_state == 1 || m_state == 2));
        check("cfg_ready", int'(bus.cfg_ready), int'(m_state == 0 || m_state == 3));
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_in(bit s, bit sp, bit p, bit cv, int cl);
        bus.start     = s;
        bus.stop      = sp;
        bus.pause     = p;
        bus.cfg_valid = cv;
        bus.cfg_limit = W'(cl);
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        ticks(2);
        check("rst_state", int'(bus.state), 0);
        check("rst_count", int'(bus.count), 0);
        check("rst_busy",  int'(bus.busy),  0);
        check("rst_done",  int'(bus.done),  0);
        check("rst_cfg_ready", int'(bus.cfg_ready), 1);
        rst = 1'b0;

`ifdef COUNT_SEQ_AUTO_RELOAD_EN
        begin
            int exp_cnt[6] = '{1, 2, 0, 1, 2, 0};
            int exp_dn[6]  = '{0, 0, 1, 0, 0, 1};
            set_in(1, 0, 0, 1, 2);
            tick();
            set_in(0, 0, 0, 0, 0);
            check("ar_start_count", int'(bus.count), 0);
            for (int i = 0; i < 6; i++) begin
                tick();
                check("ar_count", int'(bus.count), exp_cnt[i]);
                check("ar_done",  int'(bus.done),  exp_dn[i]);
                check("ar_state", int'(bus.state), 1);
            end
            set_in(0, 1, 0, 0, 0);
            tick();
            check("ar_stop_state", int'(bus.state), 0);
            set_in(0, 0, 0, 0, 0);
        end
`else
        // Default limit after reset is all ones.
        set_in(1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        check("dflt_start_state", int'(bus.state), 1);
        check("dflt_start_count", int'(bus.count), 0);
        ticks(15);
        check("dflt_top_count", int'(bus.count), 15);
        check("dflt_top_state", int'(bus.state), 1);
        tick();
        check("dflt_done_state", int'(bus.state), 3);
        check("dflt_done_pulse", int'(bus.done), 1);
        tick();
        check("dflt_done_clear", int'(bus.done), 0);
        check("dflt_done_hold",  int'(bus.count), 15);

        // Program 5 in DONE, then run.
        set_in(0, 0, 0, 1, 5);
        tick();
        set_in(1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        check("l5_count0", int'(bus.count), 0);
        ticks(5);
        check("l5_count5", int'(bus.count), 5);
        check("l5_no_done", int'(bus.done), 0);
        tick();
        check("l5_state", int'(bus.state), 3);
        check("l5_done",  int'(bus.done),  1);
        check("l5_count", int'(bus.count), 5);
        check("l5_busy",  int'(bus.busy),  0);

        // Config + start together, then pause and stop.
        set_in(1, 0, 0, 1, 9);
        tick();
        set_in(0, 0, 0, 0, 0);
        ticks(4);
        check("p_count4", int'(bus.count), 4);
        set_in(0, 0, 1, 0, 0);
        ticks(3);
        check("p_state", int'(bus.state), 2);
        check("p_hold",  int'(bus.count), 4);
        set_in(0, 0, 0, 0, 0);
        tick();
        check("p_resume_state", int'(bus.state), 1);
        tick();
        check("p_resume_count", int'(bus.count), 5);
        ticks(2);
        check("p_count7", int'(bus.count), 7);
        set_in(0, 1, 0, 0, 0);
        tick();
        check("stop_state", int'(bus.state), 0);
        check("stop_count", int'(bus.count), 0);
        check("stop_done",  int'(bus.done),  0);

        // Limit 0: exactly one RUN cycle.
        set_in(0, 0, 0, 1, 0);
        tick();
        set_in(1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        check("l0_run", int'(bus.state), 1);
        tick();
        check("l0_done_state", int'(bus.state), 3);
        check("l0_done_pulse", int'(bus.done), 1);

        // start+stop: stop wins in DONE and in IDLE.
        set_in(1, 1, 0, 0, 0);
        tick();
        check("ss_done_state", int'(bus.state), 0);
        tick();
        check("ss_idle_state", int'(bus.state), 0);
        check("ss_idle_busy",  int'(bus.busy),  0);

        // cfg write during RUN is ignored.
        set_in(0, 0, 0, 1, 3);
        tick();
        set_in(1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 1);
        tick();
        check("cr_ready", int'(bus.cfg_ready), 0);
        check("cr_count", int'(bus.count), 1);
        ticks(2);
        check("cr_past_ignored_limit", int'(bus.count), 3);
        tick();
        check("cr_done_state", int'(bus.state), 3);
        check("cr_done_count", int'(bus.count), 3);
        set_in(0, 0, 0, 0, 0);

        // Reset mid-run restores the all-ones limit.
        set_in(1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        ticks(3);
        check("mr_count3", int'(bus.count), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_state", int'(bus.state), 0);
        check("mr_count", int'(bus.count), 0);
        check("mr_done",  int'(bus.done),  0);
        check("mr_cfg_ready", int'(bus.cfg_ready), 1);
        set_in(1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        ticks(15);
        check("mr_top_count", int'(bus.count), 15);
        tick();
        check("mr_done_state", int'(bus.state), 3);
        check("mr_done_pulse", int'(bus.done), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
